mul_share_arb: RTL and testbench

- Shares one pipelined multiplier between NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake; a round-robin arbiter grants one requester per cycle.
- The product carries a requester tag through the pipeline and returns to the issuing requester only.
- Sits between DSP sub-blocks that individually need low multiply throughput and the single multiplier resource they share.

---
 rtl/mul_share_arb.sv | 124 ++++++++++++
 tb/tb_mul_share_arb.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters; results return tagged to the issuer.
// Optional per-requester grant counters are enabled with `define MUL_SHARE_STATS_EN.
module mul_share_arb #(
   parameter int NREQ    = 2,
   parameter int W0      = 16,
   parameter int W1      = 16,
   parameter int SIGNED  = 0,
   parameter int LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ*W0-1:0]   din0_data,
   input  logic [NREQ*W1-1:0]   din1_data,
   input  logic [NREQ-1:0]      din_valid,
   output logic [NREQ-1:0]      din_ready,
   output logic [W0+W1-1:0]     dout_data,
   output logic [NREQ-1:0]      dout_valid,
   input  logic [NREQ-1:0]      dout_ready
`ifdef MUL_SHARE_STATS_EN
   ,
   output logic [NREQ*16-1:0]   grant_cnt
`endif
);

   localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = W0 + W1;

   logic [LATENCY:1] v;
   logic [TW-1:0]    tag  [1:LATENCY];
   logic [PW-1:0]    prod [1:LATENCY];

   logic [TW-1:0] ptr;
   logic [TW-1:0] grant;
   logic [TW-1:0] ptr_next;
   logic          found;
   logic          adv;
   logic          hs;
   logic [W0-1:0] op_a;
   logic [W1-1:0] op_b;
   logic [PW-1:0] ext_a;
   logic [PW-1:0] ext_b;
   logic [PW-1:0] full;

   // The whole pipeline stalls together when the head result is not taken.
   assign adv = !v[LATENCY] || dout_ready[tag[LATENCY]];

   always_comb begin
      int idx;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && din_valid[idx]) begin
            found = 1'b1;
            grant = TW'(idx);
         end
      end
   end

   assign hs        = rst && adv && found;
   assign din_ready = hs ? (NREQ'(1) << grant) : '0;
   assign ptr_next  = (grant == TW'(NREQ - 1)) ? '0 : grant + 1'b1;

   // Extending to the full product width first makes the truncated product exact for both signednesses.
   always_comb begin
      op_a = din0_data[int'(grant)*W0 +: W0];
      op_b = din1_data[int'(grant)*W1 +: W1];
      if (SIGNED != 0) begin
         ext_a = {{W1{op_a[W0-1]}}, op_a};
         ext_b = {{W0{op_b[W1-1]}}, op_b};
      end else begin
         ext_a = {{W1{1'b0}}, op_a};
         ext_b = {{W0{1'b0}}, op_b};
      end
      full = ext_a * ext_b;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v   <= '0;
         ptr <= '0;
         for (int s = 1; s <= LATENCY; s++) begin
            tag[s]  <= '0;
            prod[s] <= '0;
         end
      end else if (adv) begin
         v[1]    <= hs;
         tag[1]  <= grant;
         prod[1] <= full;
         for (int s = 2; s <= LATENCY; s++) begin
            v[s]    <= v[s-1];
            tag[s]  <= tag[s-1];
            prod[s] <= prod[s-1];
         end
         if (hs) ptr <= ptr_next;
      end
   end

   assign dout_valid = v[LATENCY] ? (NREQ'(1) << tag[LATENCY]) : '0;
   assign dout_data  = prod[LATENCY];

`ifdef MUL_SHARE_STATS_EN
   logic [15:0] cnt [NREQ];

   // Saturating handshake counters, one per requester.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (din_valid[i] && din_ready[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = cnt[i];
   end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: an unsigned 2x8-bit instance with a scoreboard plus a signed instance.
module tb_mul_share_arb;

   logic        clk;
   logic        rst;
   logic [15:0] d0, d1;
   logic [1:0]  dv, drdy, ov, ordy;
   logic [15:0] odata;

   logic [15:0] sd0, sd1;
   logic [1:0]  sdv, srdy, sov, sordy;
   logic [15:0] sodata;

   int total = 0;
   int bad   = 0;

   logic [17:0] q[$];

`ifdef MUL_SHARE_STATS_EN
   logic [31:0] grant_cnt;
   logic [31:0] s_grant_cnt;
`endif

   mul_share_arb #(.NREQ(2), .W0(8), .W1(8), .SIGNED(0), .LATENCY(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .din0_data  (d0),
      .din1_data  (d1),
      .din_valid  (dv),
      .din_ready  (drdy),
      .dout_data  (odata),
      .dout_valid (ov),
      .dout_ready (ordy)
`ifdef MUL_SHARE_STATS_EN
      ,
      .grant_cnt  (grant_cnt)
`endif
   );

   mul_share_arb #(.NREQ(2), .W0(8), .W1(8), .SIGNED(1), .LATENCY(2)) u_sdut (
      .clk        (clk),
      .rst        (rst),
      .din0_data  (sd0),
      .din1_data  (sd1),
      .din_valid  (sdv),
      .din_ready  (srdy),
      .dout_data  (sodata),
      .dout_valid (sov),
      .dout_ready (sordy)
`ifdef MUL_SHARE_STATS_EN
      ,
      .grant_cnt  (s_grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scoreboard: push the expected product when a handshake is about to happen, pop when a result is consumed.
   always @(negedge clk) begin
      logic [7:0]  a, b;
      logic [17:0] exp_item;
      int          g;
      if (rst) begin
         if ((dv & drdy) != 2'b00) begin
            g = drdy[1] ? 1 : 0;
            a = d0[g*8 +: 8];
            b = d1[g*8 +: 8];
            q.push_back({drdy, {8'h00, a} * {8'h00, b}});
         end
         if (ov != 2'b00 && (ov & ordy) != 2'b00) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("[TB] FAIL sb_extra: got valid=%b data=%h, expected no result", ov, odata);
            end else begin
               exp_item = q.pop_front();
               if ({ov, odata} !== exp_item) begin
                  bad++;
                  $display("[TB] FAIL sb_result: got valid=%b data=%h, expected valid=%b data=%h",
                           ov, odata, exp_item[17:16], exp_item[15:0]);
               end
            end
         end
      end
   end

   task automatic apply_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      q.delete();
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: got %0d results outstanding, expected 0", q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      dv  = 2'b11;
      sdv = 2'b11;
      #3;
      total++;
      if (drdy !== 2'b00 || srdy !== 2'b00) begin
         bad++;
         $display("[TB] FAIL reset_ready: got %b/%b, expected 00/00", drdy, srdy);
      end
      repeat (2) @(posedge clk);
      #1;
      dv  = 2'b00;
      sdv = 2'b00;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (ov !== 2'b00 || sov !== 2'b00) begin
         bad++;
         $display("[TB] FAIL reset_valid: got %b/%b, expected 00/00", ov, sov);
      end
   endtask

   task automatic test_single();
      logic seen1 = 1'b0;
      @(posedge clk);
      #1;
      d0 = 16'h0003;
      d1 = 16'h0005;
      dv = 2'b01;
      @(negedge clk);
      if (drdy[1]) seen1 = 1'b1;
      total++;
      if (drdy !== 2'b01) begin
         bad++;
         $display("[TB] FAIL single_ready: got %b, expected 01", drdy);
      end
      @(posedge clk);
      #1 dv = 2'b00;
      @(negedge clk);
      if (drdy[1]) seen1 = 1'b1;
      total++;
      if (ov !== 2'b00) begin
         bad++;
         $display("[TB] FAIL single_early: got valid=%b, expected 00", ov);
      end
      @(negedge clk);
      if (drdy[1]) seen1 = 1'b1;
      total++;
      if (ov !== 2'b01 || odata !== 16'd15) begin
         bad++;
         $display("[TB] FAIL single_result: got valid=%b data=%0d, expected 01 and 15", ov, odata);
      end
      total++;
      if (seen1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_ready1: got din_ready[1] asserted=%b, expected 0", seen1);
      end
      wait_drain();
   endtask

   task automatic test_alternate();
      apply_reset();
      @(posedge clk);
      #1;
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      dv = 2'b11;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if (drdy !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
            bad++;
            $display("[TB] FAIL alt_grant%0d: got %b, expected %b", i, drdy,
                     (i % 2 == 0) ? 2'b01 : 2'b10);
         end
         @(posedge clk);
         #1;
         d0 = 16'($urandom);
         d1 = 16'($urandom);
      end
      dv = 2'b00;
      wait_drain();
   endtask

   task automatic test_signed();
      @(posedge clk);
      #1;
      sd0 = 16'h00FD;
      sd1 = 16'h0007;
      sdv = 2'b01;
      @(negedge clk);
      total++;
      if (srdy !== 2'b01) begin
         bad++;
         $display("[TB] FAIL signed_ready0: got %b, expected 01", srdy);
      end
      @(posedge clk);
      #1 sdv = 2'b00;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (sov !== 2'b01 || sodata !== 16'hFFEB) begin
         bad++;
         $display("[TB] FAIL signed_neg: got valid=%b data=%h, expected 01 and ffeb", sov, sodata);
      end
      @(posedge clk);
      #1;
      sd0 = 16'h8000;
      sd1 = 16'h8000;
      sdv = 2'b10;
      @(negedge clk);
      total++;
      if (srdy !== 2'b10) begin
         bad++;
         $display("[TB] FAIL signed_ready1: got %b, expected 10", srdy);
      end
      @(posedge clk);
      #1 sdv = 2'b00;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (sov !== 2'b10 || sodata !== 16'h4000) begin
         bad++;
         $display("[TB] FAIL signed_min: got valid=%b data=%h, expected 10 and 4000", sov, sodata);
      end
   endtask

   task automatic test_backpressure();
      logic        found = 1'b0;
      logic [15:0] held  = '0;
      ordy = 2'b10;
      @(posedge clk);
      #1;
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      dv = 2'b11;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (ov == 2'b01) begin
            found = 1'b1;
            held  = odata;
            break;
         end
         @(posedge clk);
         #1;
         d0 = 16'($urandom);
         d1 = 16'($urandom);
      end
      total++;
      if (found !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_stall_seen: got %b, expected 1", found);
      end
      for (int c = 0; c < 3; c++) begin
         total++;
         if (drdy !== 2'b00 || ov !== 2'b01 || odata !== held) begin
            bad++;
            $display("[TB] FAIL bp_hold%0d: got ready=%b valid=%b data=%h, expected 00 01 %h",
                     c, drdy, ov, odata, held);
         end
         @(posedge clk);
         #1;
         d0 = 16'($urandom);
         d1 = 16'($urandom);
         @(negedge clk);
      end
      @(posedge clk);
      #1 ordy = 2'b11;
      repeat (2) begin
         @(posedge clk);
         #1;
         d0 = 16'($urandom);
         d1 = 16'($urandom);
      end
      dv = 2'b00;
      wait_drain();
   endtask

   task automatic test_reset_midflight();
      @(posedge clk);
      #1;
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      dv = 2'b11;
      @(posedge clk);
      #1;
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      @(posedge clk);
      #2;
      total++;
      if ((|ov) !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_inflight: got valid=%b, expected nonzero", ov);
      end
      rst = 1'b0;
      q.delete();
      #1;
      total++;
      if (ov !== 2'b00 || drdy !== 2'b00) begin
         bad++;
         $display("[TB] FAIL mid_async: got valid=%b ready=%b, expected 00 00", ov, drdy);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      total++;
      if (drdy !== 2'b01) begin
         bad++;
         $display("[TB] FAIL mid_first_grant: got %b, expected 01", drdy);
      end
      @(posedge clk);
      #1 dv = 2'b00;
      wait_drain();
   endtask

`ifdef MUL_SHARE_STATS_EN
   task automatic test_stats();
      apply_reset();
      ordy = 2'b11;
      @(posedge clk);
      #1;
      d0 = 16'h0203;
      d1 = 16'h0405;
      dv = 2'b10;
      repeat (5) @(posedge clk);
      #1 dv = 2'b00;
      @(negedge clk);
      total++;
      if (grant_cnt !== {16'd5, 16'd0}) begin
         bad++;
         $display("[TB] FAIL stats_five: got %h, expected 00050000", grant_cnt);
      end
      @(posedge clk);
      #1 dv = 2'b10;
      repeat (70000) @(posedge clk);
      #1 dv = 2'b00;
      @(negedge clk);
      total++;
      if (grant_cnt[31:16] !== 16'hFFFF) begin
         bad++;
         $display("[TB] FAIL stats_sat: got %h, expected ffff", grant_cnt[31:16]);
      end
      wait_drain();
   endtask
`endif

   initial begin
      rst   = 1'b0;
      d0    = '0;
      d1    = '0;
      dv    = '0;
      ordy  = 2'b11;
      sd0   = '0;
      sd1   = '0;
      sdv   = '0;
      sordy = 2'b11;
      test_reset();
      test_single();
      test_alternate();
      test_signed();
      test_backpressure();
      test_reset_midflight();
`ifdef MUL_SHARE_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
